// File: rtl/stopwatch_pkg.sv
// Shared state/status encoding and command arbitration for the stopwatch control sequencer.
package stopwatch_pkg;

  localparam int unsigned STATUS_W  = 2;
  localparam int unsigned BTN_RESET = 0;
  localparam int unsigned BTN_STOP  = 1;
  localparam int unsigned BTN_START = 2;
  localparam int unsigned BTN_LAP   = 3;
  localparam int unsigned CMD_W     = 4;

  typedef enum logic [STATUS_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_RESET,
    CMD_STOP,
    CMD_START,
    CMD_LAP
  } cmd_e;

  // Fixed priority reset > stop > start > lap; losers are dropped.
  function automatic cmd_e pick_cmd(input logic [CMD_W-1:0] cmd);
    if (cmd[BTN_RESET])      return CMD_RESET;
    else if (cmd[BTN_STOP])  return CMD_STOP;
    else if (cmd[BTN_START]) return CMD_START;
    else if (cmd[BTN_LAP])   return CMD_LAP;
    else                     return CMD_NONE;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// N-bit rising-edge detector: one command per press of a level button.
module btn_edge #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_btn,
  output logic [N-1:0] o_cmd_c
);

  logic [N-1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) r_hist <= '0;
    else     r_hist <= i_btn;
  end

  assign o_cmd_c = i_btn & ~r_hist;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button commands, IDLE/RUN/PAUSE FSM, one-second prescaler.
// Optional lap-hold feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned PRESC_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                reset,
  output logic                sec_tick,
  output logic                count_clr,
  output logic [STATUS_W-1:0] status
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic                lap,
  output logic                lap_hold
`endif
);

`ifdef STOPWATCH_LAP_EN
  localparam int unsigned NBTN = 4;
`else
  localparam int unsigned NBTN = 3;
`endif

  logic [NBTN-1:0]  w_btn;
  logic [NBTN-1:0]  w_cmd_c;
  logic [CMD_W-1:0] w_cmd_all;
  cmd_e             w_cmd;
  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_clr_nxt;
  logic [PRESC_W-1:0] r_presc;
  logic             r_sec_tick;
  logic             r_count_clr;

`ifdef STOPWATCH_LAP_EN
  assign w_btn     = {lap, start, stop, reset};
  assign w_cmd_all = w_cmd_c;
`else
  assign w_btn     = {start, stop, reset};
  assign w_cmd_all = {1'b0, w_cmd_c};
`endif

  btn_edge #(.N(NBTN)) u_btn_edge (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (w_btn),
    .o_cmd_c (w_cmd_c)
  );

  assign w_cmd = pick_cmd(w_cmd_all);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
    if (w_cmd == CMD_RESET) begin
      w_state_nxt = ST_IDLE;
      w_clr_nxt   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_PAUSE: if (w_cmd == CMD_START) w_state_nxt = ST_RUN;
        ST_RUN:            if (w_cmd == CMD_STOP)  w_state_nxt = ST_PAUSE;
        default:           w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Prescaler counts while running; a wrap on the pause edge still yields its tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_sec_tick  <= 1'b0;
      r_count_clr <= 1'b0;
    end else begin
      r_count_clr <= w_clr_nxt;
      if (w_clr_nxt) begin
        r_presc    <= '0;
        r_sec_tick <= 1'b0;
      end else if (r_state == ST_RUN) begin
        if (r_presc == PRESC_W'(TICKS_PER_SEC - 1)) begin
          r_presc    <= '0;
          r_sec_tick <= 1'b1;
        end else begin
          r_presc    <= r_presc + PRESC_W'(1);
          r_sec_tick <= 1'b0;
        end
      end else begin
        r_sec_tick <= 1'b0;
        if (r_state == ST_IDLE) r_presc <= '0;
      end
    end
  end

  assign sec_tick  = r_sec_tick;
  assign count_clr = r_count_clr;
  assign status    = r_state;

`ifdef STOPWATCH_LAP_EN
  logic r_lap_hold;
  logic w_lap_nxt;

  always_comb begin
    w_lap_nxt = r_lap_hold;
    if (w_cmd == CMD_RESET || w_cmd == CMD_STOP)
      w_lap_nxt = 1'b0;
    else if (w_cmd == CMD_LAP && r_state == ST_RUN)
      w_lap_nxt = ~r_lap_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) r_lap_hold <= 1'b0;
    else     r_lap_hold <= w_lap_nxt;
  end

  assign lap_hold = r_lap_hold;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a cycle-level behavioural model.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned TPS = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       reset = 1'b0;
  logic       lap = 1'b0;
  logic       sec_tick;
  logic       count_clr;
  logic [1:0] status;
`ifdef STOPWATCH_LAP_EN
  logic       lap_hold;
`endif

  stopwatch_ctrl #(.TICKS_PER_SEC(TPS), .PRESC_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .reset     (reset),
    .sec_tick  (sec_tick),
    .count_clr (count_clr),
    .status    (status)
`ifdef STOPWATCH_LAP_EN
    ,
    .lap       (lap),
    .lap_hold  (lap_hold)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int dut_ticks = 0;

  // Model: operating mode, cycles elapsed in the current second, previous button levels.
  state_e     m_mode  = ST_IDLE;
  int         m_phase = 0;
  logic [3:0] m_prev  = '0;
  logic       exp_tick = 1'b0;
  logic       exp_clr  = 1'b0;
  logic       exp_lap  = 1'b0;
  bit         model_ok = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] now;
    logic [3:0] cmd;
    if (rst) begin
      m_mode = ST_IDLE; m_phase = 0; m_prev = '0;
      exp_tick = 1'b0; exp_clr = 1'b0; exp_lap = 1'b0;
    end else begin
      now = {lap, start, stop, reset};
      cmd = now & ~m_prev;
      m_prev = now;
      exp_tick = 1'b0;
      exp_clr  = 1'b0;
      if (cmd[0]) begin
        m_mode = ST_IDLE; m_phase = 0; exp_clr = 1'b1; exp_lap = 1'b0;
      end else begin
        if (m_mode == ST_RUN) begin
          m_phase++;
          if (m_phase == TPS) begin m_phase = 0; exp_tick = 1'b1; end
        end
        if (cmd[1]) begin
          if (m_mode == ST_RUN) m_mode = ST_PAUSE;
          exp_lap = 1'b0;
        end else if (cmd[2]) begin
          if (m_mode != ST_RUN) m_mode = ST_RUN;
        end else if (cmd[3] && m_mode == ST_RUN) begin
          exp_lap = ~exp_lap;
        end
      end
    end
    model_ok = 1'b1;
  endtask

  // Check outputs of the previous edge, then drive inputs for the next edge.
  task automatic step(input logic r, input logic st, input logic sp, input logic rs, input logic lp);
    @(negedge clk);
    if (model_ok) begin
      chk("status",    8'(status),    8'(m_mode));
      chk("sec_tick",  8'(sec_tick),  8'(exp_tick));
      chk("count_clr", 8'(count_clr), 8'(exp_clr));
`ifdef STOPWATCH_LAP_EN
      chk("lap_hold",  8'(lap_hold),  8'(exp_lap));
`endif
      if (sec_tick === 1'b1) dut_ticks++;
    end
    rst = r; start = st; stop = sp; reset = rs;
`ifdef STOPWATCH_LAP_EN
    lap = lp;
`else
    lap = 1'b0 & lp;
`endif
    model_step();
  endtask

  initial begin
    logic fs, fp, fr, fl, rr;
    // Reset two cycles, single start pulse, free run: five ticks in fifty cycles.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    dut_ticks = 0;
    repeat (51) step(0, 0, 0, 0, 0);
    chk("ticks_in_50", 8'(dut_ticks), 8'd5);

    // Pause mid-second, long pause, resume keeps partial second.
    repeat (5) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    dut_ticks = 0;
    repeat (30) step(0, 0, 0, 0, 0);
    chk("ticks_paused", 8'(dut_ticks), 8'd0);
    step(0, 1, 0, 0, 0);
    repeat (15) step(0, 0, 0, 0, 0);

    // Lap toggles while running, then all three buttons together.
    step(0, 0, 0, 0, 1);
    repeat (12) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    repeat (3) step(0, 0, 0, 0, 0);

    // Start held for 40 cycles with a stop in the middle; no restart until re-press.
    repeat (20) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (19) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // Reset command mid-second, then start, then rst while running.
    repeat (6) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    repeat (14) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // Randomized button activity with occasional rst.
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      fs = ($urandom_range(0, 7) == 0);
      fp = ($urandom_range(0, 19) == 0);
      fr = ($urandom_range(0, 39) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step(rr, start ^ fs, stop ^ fp, reset ^ fr, lap ^ fl);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control sequencer for the stopwatch minutes/seconds counter datapath.
- Converts level start/stop/reset button inputs into single accepted commands, with priority arbitration.
- Runs the IDLE/RUNNING/PAUSED state machine and generates the one-second count enable from a prescaler.
- Drives the counter's enable and clear inputs and the 2-bit status bus seen at top level.

Parameters:
- TICKS_PER_SEC, 100, clk cycles per counted second; legal range ≥ 2. Sim uses small values.
- PRESC_W, 16, prescaler counter width; must satisfy 2^PRESC_W ≥ TICKS_PER_SEC.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  start/resume button, level
- stop  input  1  pause button, level
- reset  input  1  clear-to-zero button, level
- sec_tick  output  1  one-cycle count enable to the seconds/minutes datapath
- count_clr  output  1  one-cycle synchronous clear to the datapath
- status  output  2  00 IDLE, 01 RUNNING, 10 PAUSED; 11 never driven

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - rst is synchronous, active-high and sampled at posedge clk. It overrides everything.
  - On rst: state=IDLE, prescaler=0, sec_tick=0, count_clr=0, status=00, edge-history regs=0.
- Edge detection:
  - Per button, hist_q holds the previous sample.
  - cmd_x = x & ~hist_q. A cmd is recognised at the first posedge where the input is high.
  - Holding a button produces exactly one command.
  - History regs are 0 after rst, so a button held through rst release yields one command on the first post-rst edge.
- Arbitration of simultaneous commands in the same cycle: reset > stop > start. Lower-priority commands that cycle are dropped, not queued.
- FSM, transitions take effect at the same posedge the cmd is recognised:
  - IDLE:
    - start -> RUNNING.
    - stop ignored.
    - reset -> stays IDLE, count_clr pulses.
  - RUNNING:
    - stop -> PAUSED.
    - reset -> IDLE with count_clr.
    - start ignored.
  - PAUSED:
    - start -> RUNNING.
    - reset -> IDLE with count_clr.
    - stop ignored.
- status is registered and equals the state encoding; it changes at the transition edge.
- Prescaler:
  - Increments every cycle while state==RUNNING.
  - At value TICKS_PER_SEC-1 it wraps to 0, and sec_tick is registered high for exactly the following cycle.
  - Holds its value in PAUSED, so resume keeps the partial second. Cleared to 0 in IDLE and on any accepted reset.
  - First sec_tick after start-from-IDLE is asserted TICKS_PER_SEC cycles after the start edge.
- sec_tick and stop in the same cycle as a wrap: the wrap-generated tick is still issued (tick ≤ 1 cycle after the pause).
- count_clr is registered and high for exactly 1 cycle after an accepted reset command. sec_tick is forced 0 in that same cycle.
- Reset command mid-second: prescaler discards the partial count; no tick is issued.
- Datapath contract: minute/second wrap arithmetic stays in the datapath; this block never issues more than one sec_tick per TICKS_PER_SEC cycles.

Optional Feature:
- Macro STOPWATCH_LAP_EN.
- When defined:
  - Adds input lap (level, edge-detected, lowest priority) and output lap_hold (1 bit, reset 0).
  - A lap cmd in RUNNING toggles lap_hold. While lap_hold=1 the top level freezes its display registers; counting continues.
  - lap_hold is cleared by stop, by an accepted reset, and by rst.
- When undefined: no lap port, no lap_hold logic, behaviour identical to the base spec.

Decomposition:
- Shared package stopwatch_pkg:
  - State typedef with constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10.
  - Status encoding shared with the datapath and testbench.
- One natural sub-module: btn_edge. A parameterised N-bit rising-edge detector with synchronous active-high reset, instantiated once for the 3 (or 4) buttons.
- Prescaler and FSM stay in stopwatch_ctrl.

Test Plan:
- TICKS_PER_SEC=10: rst 2 cycles, start pulse 1 cycle -> status=01 at that edge; sec_tick pulses every 10 cycles; 5 ticks in 50 cycles.
- Running, stop at prescaler=6, wait 30 cycles, start -> status 10 then 01; no ticks while paused; first tick 4 cycles after resume.
- start, stop and reset all high in one cycle while RUNNING -> status=00 next, count_clr high exactly 1 cycle, sec_tick 0.
- start held high for 40 cycles from IDLE -> one transition to 01; stop while start still held -> 10, no re-start until start falls and rises again.
- Reset command with prescaler=7 then start -> first tick 10 cycles after start, not 3; rst asserted while RUNNING -> all outputs 0 next cycle.
- STOPWATCH_LAP_EN defined: lap in RUNNING -> lap_hold=1 while ticks continue; stop -> lap_hold=0 and status=10.
